// File: rtl/jstk_spi_responder_pkg.sv
// ------------------------------------------------------------------
// jstk_pkg : shared constants, types and byte map for jstk_spi_responder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package jstk_pkg;

  localparam logic [5:0] JSTK_CMD_PREFIX  = 6'b100000;
  localparam int         JSTK_FRAME_BYTES = 5;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_END       = 2'd3
  } jstk_state_e;

  localparam logic [3:0] BYTE_X_LO = 4'd0;
  localparam logic [3:0] BYTE_X_HI = 4'd1;
  localparam logic [3:0] BYTE_Y_LO = 4'd2;
  localparam logic [3:0] BYTE_Y_HI = 4'd3;
  localparam logic [3:0] BYTE_BTN  = 4'd4;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] btn;
  } jstk_frame_t;

  // Indices at or past nbytes read as zero so long frames pad cleanly.
  function automatic logic [7:0] jstk_frame_byte(input jstk_frame_t f,
                                                 input logic [3:0] idx,
                                                 input logic [3:0] nbytes);
    logic [7:0] b;
    b = 8'h00;
    if (idx < nbytes) begin
      case (idx)
        BYTE_X_LO: b = f.x[7:0];
        BYTE_X_HI: b = {6'b0, f.x[9:8]};
        BYTE_Y_LO: b = f.y[7:0];
        BYTE_Y_HI: b = {6'b0, f.y[9:8]};
        BYTE_BTN:  b = {5'b0, f.btn};
        default:   b = 8'h00;
      endcase
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jstk_spi_responder_if.sv
// ------------------------------------------------------------------
// jstk_spi_responder_if : SPI pin bundle between master and responder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface jstk_spi_responder_if;
  logic SCLK;
  logic SS;
  logic MOSI;
  logic MISO;
  logic MISO_OE;

  modport master (output SCLK, output SS, output MOSI, input MISO, input MISO_OE);
  modport slave  (input SCLK, input SS, input MOSI, output MISO, output MISO_OE);
endinterface

`default_nettype wire

// File: rtl/jstk_spi_responder_sync_edge.sv
// ------------------------------------------------------------------
// sync_edge : multi-stage synchronizer with rise/fall event pulses
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Chain resets low so a select held low through reset never looks idle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

`default_nettype wire

// File: rtl/jstk_spi_responder.sv
// ------------------------------------------------------------------
// jstk_spi_responder : PmodJSTK-compatible SPI mode-0 slave emulator
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int FRAME_BYTES = JSTK_FRAME_BYTES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  jstk_spi_responder_if.slave  spi,
  input  logic [9:0]           X,
  input  logic [9:0]           Y,
  input  logic [2:0]           BTN,
  output logic [1:0]           LEDS,
  output logic                 FRAME_DONE,
  output logic [2:0]           BYTE_COUNT
);

  localparam logic [3:0] C_NBYTES = 4'(FRAME_BYTES);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .CLK(CLK), .RESET(RESET), .d_i(spi.SCLK),
    .q_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .CLK(CLK), .RESET(RESET), .d_i(spi.SS),
    .q_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .CLK(CLK), .RESET(RESET), .d_i(spi.MOSI),
    .q_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  jstk_state_e state_q, state_d;
  jstk_frame_t frame_q, frame_d, pin_frame;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [1:0]  leds_q, leds_d;
  logic        miso_q, miso_d;
  logic        miso_oe_q, miso_oe_d;
  logic        frame_done_q, frame_done_d;
  logic [2:0]  byte_count_q, byte_count_d;

  logic [2:0]  byte_cnt_inc;
  logic        last_full;
  logic [2:0]  final_cnt;
  logic [7:0]  final_cmd;

  assign pin_frame    = {X, Y, BTN};
  assign byte_cnt_inc = (byte_cnt_q == 3'd7) ? 3'd7 : byte_cnt_q + 3'd1;
  // A byte whose 8th bit landed just before SS rose still counts.
  assign last_full    = (bit_cnt_q == 4'd8);
  assign final_cnt    = last_full ? byte_cnt_inc : byte_cnt_q;
  assign final_cmd    = (last_full && byte_cnt_q == 3'd0) ? rx_sr_q : cmd_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_WAIT_IDLE;
      frame_q      <= '0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      cmd_q        <= '0;
      leds_q       <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      frame_done_q <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      cmd_q        <= cmd_d;
      leds_q       <= leds_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      frame_done_q <= frame_done_d;
      byte_count_q <= byte_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    cmd_d        = cmd_q;
    leds_d       = leds_q;
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    frame_done_d = 1'b0;
    byte_count_d = byte_count_q;

    unique case (state_q)
      ST_WAIT_IDLE: begin
        if (ss_sync) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (ss_fall) begin
          frame_d    = pin_frame;
          tx_sr_d    = jstk_frame_byte(pin_frame, BYTE_X_LO, C_NBYTES);
          miso_d     = tx_sr_d[7];
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          rx_sr_d    = '0;
          miso_oe_d  = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_END;
        end else if (sclk_rise) begin
          rx_sr_d   = {rx_sr_q[6:0], mosi_sync};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (sclk_fall) begin
          if (last_full) begin
            // Index one past the completed count; unsaturated so bytes 8+ pad.
            tx_sr_d    = jstk_frame_byte(frame_q, {1'b0, byte_cnt_q} + 4'd1, C_NBYTES);
            bit_cnt_d  = '0;
            byte_cnt_d = byte_cnt_inc;
            if (byte_cnt_q == 3'd0) cmd_d = rx_sr_q;
          end else begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
          miso_d = tx_sr_d[7];
        end
      end
      ST_END: begin
        cmd_d = final_cmd;
        if (final_cnt != 3'd0 && final_cmd[7:2] == JSTK_CMD_PREFIX)
          leds_d = final_cmd[1:0];
        byte_count_d = final_cnt;
        frame_done_d = 1'b1;
        miso_oe_d    = 1'b0;
        miso_d       = 1'b0;
        tx_sr_d      = '0;
        bit_cnt_d    = '0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  assign spi.MISO    = miso_q;
  assign spi.MISO_OE = miso_oe_q;
  assign LEDS        = leds_q;
  assign FRAME_DONE  = frame_done_q;
  assign BYTE_COUNT  = byte_count_q;

endmodule

`default_nettype wire

// File: tb/tb_jstk_spi_responder.sv
// ------------------------------------------------------------------
// tb_jstk_spi_responder : table-driven bench for jstk_spi_responder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_jstk_spi_responder;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  btn;
    logic [9:0]  x_late;   // X value applied from bit 8 onwards
    logic [7:0]  nbits;
    logic [7:0]  cmd;      // first MOSI byte
    logic [7:0]  fill;     // MOSI for later bytes
    logic [71:0] exp;      // expected MISO bytes, byte0 in the MSBs
    logic [1:0]  exp_leds;
    logic [2:0]  exp_cnt;
  } vec_t;

  logic       CLK;
  logic       RESET;
  logic [9:0] X;
  logic [9:0] Y;
  logic [2:0] BTN;
  logic [1:0] LEDS;
  logic       FRAME_DONE;
  logic [2:0] BYTE_COUNT;

  jstk_spi_responder_if spi_if ();

  jstk_spi_responder dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .spi       (spi_if),
    .X         (X),
    .Y         (Y),
    .BTN       (BTN),
    .LEDS      (LEDS),
    .FRAME_DONE(FRAME_DONE),
    .BYTE_COUNT(BYTE_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  always @(negedge CLK) if (FRAME_DONE === 1'b1) done_cnt++;

  vec_t       vecs [6];
  logic [7:0] rx_bytes [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sclk_cycle();
    repeat (8) @(negedge CLK);
    spi_if.SCLK = 1'b1;
    repeat (8) @(negedge CLK);
    spi_if.SCLK = 1'b0;
  endtask

  task automatic apply_vec(input int k);
    vec_t v;
    int   done0;
    int   nb;
    logic [7:0] b;
    v = vecs[k];
    X = v.x; Y = v.y; BTN = v.btn;
    done0 = done_cnt;
    @(negedge CLK);
    spi_if.SS = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < int'(v.nbits); i++) begin
      b = (i < 8) ? v.cmd : v.fill;
      spi_if.MOSI = b[7 - (i % 8)];
      if (i == 8) X = v.x_late;
      repeat (8) @(negedge CLK);
      rx_bytes[i / 8][7 - (i % 8)] = spi_if.MISO;
      if (i == 0) check($sformatf("v%0d oe", k), 32'(spi_if.MISO_OE), 32'd1);
      spi_if.SCLK = 1'b1;
      repeat (8) @(negedge CLK);
      spi_if.SCLK = 1'b0;
    end
    repeat (8) @(negedge CLK);
    spi_if.SS = 1'b1;
    repeat (20) @(negedge CLK);
    nb = int'(v.nbits) / 8;
    for (int j = 0; j < nb; j++)
      check($sformatf("v%0d byte%0d", k, j), 32'(rx_bytes[j]), 32'(v.exp[71 - 8*j -: 8]));
    check($sformatf("v%0d leds", k), 32'(LEDS), 32'(v.exp_leds));
    check($sformatf("v%0d byte_count", k), 32'(BYTE_COUNT), 32'(v.exp_cnt));
    check($sformatf("v%0d done_pulses", k), 32'(done_cnt - done0), 32'd1);
    check($sformatf("v%0d oe_idle", k), 32'(spi_if.MISO_OE), 32'd0);
  endtask

  initial begin
    vecs[0] = '{x:10'h2A5, y:10'h13C, btn:3'b101, x_late:10'h2A5, nbits:8'd40, cmd:8'h83, fill:8'h00,
                exp:72'hA5_02_3C_01_05_00_00_00_00, exp_leds:2'b11, exp_cnt:3'd5};
    vecs[1] = '{x:10'h2A5, y:10'h13C, btn:3'b101, x_late:10'h000, nbits:8'd40, cmd:8'h83, fill:8'h00,
                exp:72'hA5_02_3C_01_05_00_00_00_00, exp_leds:2'b11, exp_cnt:3'd5};
    vecs[2] = '{x:10'h3FF, y:10'h000, btn:3'b010, x_late:10'h3FF, nbits:8'd56, cmd:8'h81, fill:8'h00,
                exp:72'hFF_03_00_00_02_00_00_00_00, exp_leds:2'b01, exp_cnt:3'd7};
    vecs[3] = '{x:10'h155, y:10'h2AA, btn:3'b111, x_late:10'h155, nbits:8'd40, cmd:8'h43, fill:8'h83,
                exp:72'h55_01_AA_02_07_00_00_00_00, exp_leds:2'b01, exp_cnt:3'd5};
    vecs[4] = '{x:10'h0F0, y:10'h000, btn:3'b000, x_late:10'h0F0, nbits:8'd12, cmd:8'h82, fill:8'h00,
                exp:72'hF0_00_00_00_00_00_00_00_00, exp_leds:2'b10, exp_cnt:3'd1};
    vecs[5] = '{x:10'h1AB, y:10'h3CD, btn:3'b001, x_late:10'h1AB, nbits:8'd72, cmd:8'h80, fill:8'h00,
                exp:72'hAB_01_CD_03_01_00_00_00_00, exp_leds:2'b00, exp_cnt:3'd7};

    RESET = 1'b1;
    spi_if.SS = 1'b1; spi_if.SCLK = 1'b0; spi_if.MOSI = 1'b0;
    X = '0; Y = '0; BTN = '0;
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst miso", 32'(spi_if.MISO), 32'd0);
    check("rst oe", 32'(spi_if.MISO_OE), 32'd0);
    check("rst leds", 32'(LEDS), 32'd0);
    check("rst done", 32'(FRAME_DONE), 32'd0);
    check("rst byte_count", 32'(BYTE_COUNT), 32'd0);
    repeat (10) @(negedge CLK);

    for (int k = 0; k < 6; k++) apply_vec(k);

    // Reset in mid-frame with SS held low: responder must stay quiet.
    begin
      int done0;
      done0 = done_cnt;
      X = 10'h2A5; Y = 10'h13C; BTN = 3'b101;
      spi_if.MOSI = 1'b1;
      spi_if.SS = 1'b0;
      repeat (8) @(negedge CLK);
      for (int i = 0; i < 10; i++) sclk_cycle();
      check("mid oe_active", 32'(spi_if.MISO_OE), 32'd1);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      check("mid rst leds", 32'(LEDS), 32'd0);
      check("mid rst byte_count", 32'(BYTE_COUNT), 32'd0);
      for (int i = 0; i < 10; i++) begin
        sclk_cycle();
        check($sformatf("mid oe%0d", i), 32'(spi_if.MISO_OE), 32'd0);
        check($sformatf("mid miso%0d", i), 32'(spi_if.MISO), 32'd0);
      end
      spi_if.SS = 1'b1;
      repeat (20) @(negedge CLK);
      check("mid done_pulses", 32'(done_cnt - done0), 32'd0);
    end
    apply_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
